controler_afisaj: RTL and testbench

Sequencing controller for the 4-digit multiplexed 7-segment display of the line-follower car. It arbitrates which indication owns the display: stop (highest priority), then left/right turn, then the elapsed-time readout. It generates the blink timing for turn indications and the scan-enable tick. It also runs the 00-99 seconds BCD counter that feeds the tens/units digits.

---
 rtl/controler_afisaj.sv | 160 ++++++++++++++++
 tb/tb_controler_afisaj.sv | 136 +++++++++++++
 2 files changed

// File: rtl/controler_afisaj.sv
// Display sequencing controller for the line-follower car: arbitrates stop/turn/timer
// ownership of the 4-digit display, generates blink and scan timing, and runs the 00-99 s timer.
module controler_afisaj #(
  parameter int SCAN_DIV    = 50000,
  parameter int SEC_DIV     = 50000000,
  parameter int BLINK_DIV   = 12500000,
  parameter int HOLD_HALVES = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       cerere_stanga,
  input  logic       cerere_dreapta,
  input  logic       cerere_stop,
  input  logic       run_en,
  input  logic       clear_timer,
  output logic       scan_en,
  output logic       semnal_stanga,
  output logic       semnal_dreapta,
  output logic       stop,
  output logic [3:0] cifra_zeci,
  output logic [3:0] cifra_unitati,
  output logic [1:0] stare
);

  localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int SEC_W   = (SEC_DIV   > 1) ? $clog2(SEC_DIV)   : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int HOLD_W  = (HOLD_HALVES > 0) ? $clog2(HOLD_HALVES + 1) : 1;

  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [SEC_W-1:0]   SEC_LAST   = SEC_W'(SEC_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [HOLD_W-1:0]  HOLD_INIT  = HOLD_W'(HOLD_HALVES);

  typedef enum logic [1:0] {
    S_TIMER  = 2'b00,
    S_TURN_L = 2'b01,
    S_TURN_R = 2'b10,
    S_STOP   = 2'b11
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [BLINK_W-1:0]  r_blink_cnt, w_blink_cnt_nxt;
  logic                r_phase, w_phase_nxt;
  logic [HOLD_W-1:0]   r_hold, w_hold_nxt;
  logic [SCAN_W-1:0]   r_scan_cnt;
  logic [SEC_W-1:0]    r_pre;
  logic [3:0]          r_zeci, r_unit;

  logic w_req_l, w_req_r, w_half_end, w_sec_run, w_sec_tick;

  // Both requests high is treated the same as no request.
  assign w_req_l    = cerere_stanga & ~cerere_dreapta;
  assign w_req_r    = cerere_dreapta & ~cerere_stanga;
  assign w_half_end = (r_blink_cnt == BLINK_LAST);

  always_comb begin
    w_state_nxt     = r_state;
    w_hold_nxt      = r_hold;
    w_blink_cnt_nxt = '0;
    w_phase_nxt     = 1'b1;

    if (cerere_stop) begin
      w_state_nxt = S_STOP;
    end else begin
      case (r_state)
        S_STOP: begin
          if (w_req_l)      w_state_nxt = S_TURN_L;
          else if (w_req_r) w_state_nxt = S_TURN_R;
          else              w_state_nxt = S_TIMER;
        end
        S_TIMER: begin
          if (w_req_l)      w_state_nxt = S_TURN_L;
          else if (w_req_r) w_state_nxt = S_TURN_R;
        end
        S_TURN_L: begin
          if (w_req_r)      w_state_nxt = S_TURN_R;
          else if (w_req_l) w_hold_nxt  = HOLD_INIT;
          else if (w_half_end) begin
            if (r_hold <= HOLD_W'(1)) w_state_nxt = S_TIMER;
            else                      w_hold_nxt  = r_hold - HOLD_W'(1);
          end
        end
        S_TURN_R: begin
          if (w_req_l)      w_state_nxt = S_TURN_L;
          else if (w_req_r) w_hold_nxt  = HOLD_INIT;
          else if (w_half_end) begin
            if (r_hold <= HOLD_W'(1)) w_state_nxt = S_TIMER;
            else                      w_hold_nxt  = r_hold - HOLD_W'(1);
          end
        end
        default: w_state_nxt = S_TIMER;
      endcase
    end

    // Entering a turn state restarts blink at phase 1 with a full hold.
    if (w_state_nxt == S_TURN_L || w_state_nxt == S_TURN_R) begin
      if (w_state_nxt != r_state) begin
        w_hold_nxt = HOLD_INIT;
      end else if (w_half_end) begin
        w_phase_nxt = ~r_phase;
      end else begin
        w_blink_cnt_nxt = r_blink_cnt + BLINK_W'(1);
        w_phase_nxt     = r_phase;
      end
    end else begin
      w_hold_nxt = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state     <= S_TIMER;
      r_blink_cnt <= '0;
      r_phase     <= 1'b1;
      r_hold      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_blink_cnt <= w_blink_cnt_nxt;
      r_phase     <= w_phase_nxt;
      r_hold      <= w_hold_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n || r_scan_cnt == SCAN_LAST) r_scan_cnt <= '0;
    else                                     r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
  end

  // The timer freezes while the display shows STOP.
  assign w_sec_run  = run_en && (r_state != S_STOP);
  assign w_sec_tick = w_sec_run && (r_pre == SEC_LAST);

  always_ff @(posedge clock) begin
    if (!reset_n || clear_timer) begin
      r_pre  <= '0;
      r_zeci <= 4'd0;
      r_unit <= 4'd0;
    end else if (w_sec_tick) begin
      r_pre <= '0;
      if (r_unit == 4'd9) begin
        r_unit <= 4'd0;
        r_zeci <= (r_zeci == 4'd9) ? 4'd0 : r_zeci + 4'd1;
      end else begin
        r_unit <= r_unit + 4'd1;
      end
    end else if (w_sec_run) begin
      r_pre <= r_pre + SEC_W'(1);
    end
  end

  assign scan_en        = (r_scan_cnt == SCAN_LAST);
  assign semnal_stanga  = (r_state == S_TURN_L) & r_phase;
  assign semnal_dreapta = (r_state == S_TURN_R) & r_phase;
  assign stop           = (r_state == S_STOP);
  assign cifra_zeci     = r_zeci;
  assign cifra_unitati  = r_unit;
  assign stare          = r_state;

endmodule

// File: tb/tb_controler_afisaj.sv
// Directed bench for controler_afisaj with small dividers (4/20/5, hold of 2 half-periods).
module tb_controler_afisaj;

  logic       clock = 1'b0;
  logic       reset_n, cerere_stanga, cerere_dreapta, cerere_stop, run_en, clear_timer;
  logic       scan_en, semnal_stanga, semnal_dreapta, stop;
  logic [3:0] cifra_zeci, cifra_unitati;
  logic [1:0] stare;

  int n_chk  = 0;
  int n_pass = 0;

  controler_afisaj #(
    .SCAN_DIV(4), .SEC_DIV(20), .BLINK_DIV(5), .HOLD_HALVES(2)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .cerere_stanga(cerere_stanga), .cerere_dreapta(cerere_dreapta),
    .cerere_stop(cerere_stop), .run_en(run_en), .clear_timer(clear_timer),
    .scan_en(scan_en), .semnal_stanga(semnal_stanga), .semnal_dreapta(semnal_dreapta),
    .stop(stop), .cifra_zeci(cifra_zeci), .cifra_unitati(cifra_unitati), .stare(stare)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic [1:0] st, input logic sl,
                          input logic sd, input logic sp);
    chk({tag, ".stare"}, 32'(stare), 32'(st));
    chk({tag, ".stanga"}, 32'(semnal_stanga), 32'(sl));
    chk({tag, ".dreapta"}, 32'(semnal_dreapta), 32'(sd));
    chk({tag, ".stop"}, 32'(stop), 32'(sp));
  endtask

  task automatic chk_digits(input string tag, input int z, input int u);
    chk({tag, ".zeci"}, 32'(cifra_zeci), 32'(z));
    chk({tag, ".unitati"}, 32'(cifra_unitati), 32'(u));
  endtask

  initial begin
    reset_n = 1'b0; cerere_stanga = 1'b0; cerere_dreapta = 1'b0;
    cerere_stop = 1'b0; run_en = 1'b0; clear_timer = 1'b0;
    step(2);
    chk_outs("reset", 2'b00, 1'b0, 1'b0, 1'b0);
    chk_digits("reset", 0, 0);
    chk("reset.scan_en", 32'(scan_en), 0);

    // Timer and scan strobe from reset; cycle k = k edges after the reset edge.
    reset_n = 1'b1;
    run_en  = 1'b1;
    step(2); chk("scan.c2", 32'(scan_en), 0);
    step(1); chk("scan.c3", 32'(scan_en), 1);
    step(1); chk("scan.c4", 32'(scan_en), 0);
    step(3); chk("scan.c7", 32'(scan_en), 1);
    step(4); chk("scan.c11", 32'(scan_en), 1);
    step(29);
    chk_digits("t40", 0, 2);
    chk("t40.stare", 32'(stare), 0);

    // Wrap 99 -> 00.
    step(1940); chk_digits("t99", 9, 9);
    step(20);   chk_digits("wrap", 0, 0);
    step(60);   chk_digits("t3", 0, 3);
    step(19);
    clear_timer = 1'b1;
    step(1);
    clear_timer = 1'b0;
    chk_digits("clr_tick", 0, 0);
    step(19);   chk_digits("clr.pre19", 0, 0);
    step(1);    chk_digits("clr.pre20", 0, 1);
    run_en = 1'b0;

    // Left request for 12 cycles, then hold for two half-periods.
    cerere_stanga = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      logic exp_on;
      step(1);
      if (k == 12) cerere_stanga = 1'b0;
      exp_on = (k <= 20) && ((((k - 1) / 5) % 2) == 0);
      chk($sformatf("blinkL.k%0d.stare", k), 32'(stare), (k <= 20) ? 1 : 0);
      chk($sformatf("blinkL.k%0d.sem", k), 32'(semnal_stanga), 32'(exp_on));
    end

    // Both requests high counts as no request; dropping left then selects right.
    cerere_stanga = 1'b1;
    step(1); chk_outs("l_entry", 2'b01, 1'b1, 1'b0, 1'b0);
    cerere_dreapta = 1'b1;
    step(3); chk_outs("both_hi", 2'b01, 1'b1, 1'b0, 1'b0);
    cerere_stanga = 1'b0;
    step(1); chk_outs("to_r", 2'b10, 1'b0, 1'b1, 1'b0);

    // Timer runs in TURN_R, freezes in STOP, resumes after release.
    run_en = 1'b1;
    step(25);
    chk_digits("r_run", 0, 2);
    chk("r_run.stare", 32'(stare), 2);
    cerere_stop = 1'b1;
    step(1);
    cerere_dreapta = 1'b0;
    chk_outs("stop_in", 2'b11, 1'b0, 1'b0, 1'b1);
    step(29);
    chk_digits("frozen", 0, 2);
    chk_outs("stop_hold", 2'b11, 1'b0, 1'b0, 1'b1);
    cerere_stop = 1'b0;
    step(1);  chk_outs("stop_out", 2'b00, 1'b0, 1'b0, 1'b0);
    step(13); chk_digits("resume.pre19", 0, 2);
    step(1);  chk_digits("resume.tick", 0, 3);

    // Reset mid-blink.
    cerere_stanga = 1'b1;
    step(3); chk_outs("pre_rst", 2'b01, 1'b1, 1'b0, 1'b0);
    reset_n = 1'b0;
    step(1);
    chk_outs("mid_rst", 2'b00, 1'b0, 1'b0, 1'b0);
    chk_digits("mid_rst", 0, 0);
    chk("mid_rst.scan_en", 32'(scan_en), 0);
    reset_n = 1'b1; cerere_stanga = 1'b0; run_en = 1'b0;
    step(2); chk("post_rst.scan_c2", 32'(scan_en), 0);
    step(1); chk("post_rst.scan_c3", 32'(scan_en), 1);
    chk("post_rst.stare", 32'(stare), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
